demux_1x8_reg_n: RTL and testbench
==================================

// Module: demux_1x8_reg_n
// PURPOSE
//   Registered 1-to-8 demultiplexer: routes one BITS-wide input word into one of
//   eight holding registers, selected by SEL or by an internal auto-increment pointer.
//   It is the write-side counterpart of the 8-to-1 word mux.
//   It fills a bank of eight words that the datapath later reads back through the mux.
//   It tracks which slots have been written and flags when all eight are loaded.
// PARAMETERS
//   BITS   4   width of each data word and each holding register
// PORTS
//   clock   in   1      rising-edge clock
//   reset   in   1      synchronous, active-high reset
//   clear   in   1      synchronous clear of bank, flags and pointer
//   load    in   1      write D into the selected slot on this edge
//   auto    in   1      1: slot = internal ptr (then ptr++); 0: slot = SEL
//   SEL     in   3      explicit slot index when auto=0
//   D       in   BITS   data word to store
//   Q0..Q7  out  BITS   holding registers, each a separate port
//   valid   out  8      bit i = 1 once Qi is written since the last reset/clear
//   ptr     out  3      current auto-increment slot index
//   full    out  1      &valid
//   done    out  1      one-cycle pulse when the bank becomes full
// BEHAVIOUR
//   - Reset values (reset=1 at an edge):
//     Q0..Q7 = 0, valid = 8'h00, ptr = 0, full = 0, done = 0.
//   - Priority: reset > clear > load.
//   - clear=1 has the same effect as reset. A load in the same cycle is ignored.
//   - Write (load=1, no reset/clear):
//     - dest = auto ? ptr : SEL.
//     - Q[dest] <= D and valid[dest] <= 1.
//     - Other Qi and valid bits are unchanged.
//     - Latency: the new Q value is visible 1 cycle after the load edge.
//   - Pointer:
//     - ptr <= ptr+1 only when load=1 and auto=1; it wraps 7 -> 0.
//     - ptr holds when auto=0, even if load=1.
//     - Changing auto mid-sequence does not reset ptr.
//   - State, derived from valid:
//     - EMPTY (valid=0) -> FILLING (first load) -> FULL (valid=8'hFF).
//     - FULL and FILLING return to EMPTY only via reset or clear.
//   - full is registered and equals &valid in the same cycle.
//   - done:
//     - Registered; done <= load & ~full & (valid | onehot(dest)) == 8'hFF.
//     - It is high for exactly 1 cycle, aligned with full rising.
//   - Overwrite:
//     - Loading an already-valid slot updates Q only; the valid count does not change.
//     - In FULL, loads still overwrite and full stays 1. No new done pulse.
//   - D, SEL and auto are sampled only at edges where load=1. Their values are otherwise don't-care.
//   - Widths: valid and ptr are fixed at 8 and 3 bits, independent of BITS.
// TESTING
//   1 Reset for 2 cycles
//     -> Q0..Q7=0, valid=8'h00, ptr=0, full=0, done=0.
//   2 BITS=4, auto=0, SEL=5, D=4'hA, load for 1 cycle
//     -> next cycle Q5=4'hA, valid=8'b0010_0000; other Q=0, ptr=0.
//   3 auto=1, 8 back-to-back loads with D=1..8
//     -> Q0..Q7=1..8 and ptr wraps to 0.
//     -> full=1 after the 8th edge; done=1 for exactly that cycle.
//   4 From FULL: auto=0, SEL=2, D=4'hF, load
//     -> Q2=4'hF, full stays 1, done stays 0.
//   5 Load SEL=3 twice, then SEL=4
//     -> valid=8'b0001_1000, full=0.
//   6 clear=1 with load=1, D=4'h7
//     -> all cleared, load ignored.
//     Reset after 3 auto loads -> ptr=0, valid=0.

Source files
------------

// File: rtl/demux_1x8_reg_n.sv
// Registered 1-to-8 demultiplexer: writes D into one of eight holding registers
// chosen by SEL or an auto-increment pointer, tracking written slots and fill completion.
module demux_1x8_reg_n #(
    parameter int unsigned BITS = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            load,
    input  logic            auto,
    input  logic [2:0]      SEL,
    input  logic [BITS-1:0] D,
    output logic [BITS-1:0] Q0,
    output logic [BITS-1:0] Q1,
    output logic [BITS-1:0] Q2,
    output logic [BITS-1:0] Q3,
    output logic [BITS-1:0] Q4,
    output logic [BITS-1:0] Q5,
    output logic [BITS-1:0] Q6,
    output logic [BITS-1:0] Q7,
    output logic [7:0]      valid,
    output logic [2:0]      ptr,
    output logic            full,
    output logic            done
);

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned PTR_W     = 3;

    logic [BITS-1:0]      bank_q [NUM_SLOTS];
    logic [BITS-1:0]      bank_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 full_q, full_d;
    logic                 done_q, done_d;
    logic [PTR_W-1:0]     dest_c;
    logic [NUM_SLOTS-1:0] dest_onehot_c;

    // Next-state: clear wins over load; done fires only on the edge that completes the bank.
    always_comb begin
        dest_c        = auto ? ptr_q : SEL;
        dest_onehot_c = NUM_SLOTS'(1) << dest_c;
        bank_d        = bank_q;
        valid_d       = valid_q;
        ptr_d         = ptr_q;
        done_d        = 1'b0;
        if (clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                bank_d[i] = '0;
            end
            valid_d = '0;
            ptr_d   = '0;
        end else if (load) begin
            bank_d[dest_c] = D;
            valid_d        = valid_q | dest_onehot_c;
            if (auto) begin
                ptr_d = ptr_q + PTR_W'(1);
            end
            done_d = ~full_q & (&(valid_q | dest_onehot_c));
        end
        full_d = &valid_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                bank_q[i] <= '0;
            end
            valid_q <= '0;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                bank_q[i] <= bank_d[i];
            end
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            done_q  <= done_d;
        end
    end

    assign Q0    = bank_q[0];
    assign Q1    = bank_q[1];
    assign Q2    = bank_q[2];
    assign Q3    = bank_q[3];
    assign Q4    = bank_q[4];
    assign Q5    = bank_q[5];
    assign Q6    = bank_q[6];
    assign Q7    = bank_q[7];
    assign valid = valid_q;
    assign ptr   = ptr_q;
    assign full  = full_q;
    assign done  = done_q;

endmodule

// File: tb/tb_demux_1x8_reg_n.sv
// Directed bench for demux_1x8_reg_n: explicit/auto writes, fill/done, overwrite, clear and reset.
module tb_demux_1x8_reg_n;

    logic       clock = 1'b0;
    logic       reset, clear, load, auto;
    logic [2:0] SEL;
    logic [3:0] D;
    logic [3:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic [7:0] valid;
    logic [2:0] ptr;
    logic       full, done;
    logic [3:0] q_obs [8];
    logic [3:0] exp_q [8];

    int errors = 0;
    int checks = 0;

    demux_1x8_reg_n #(.BITS(4)) dut (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .auto(auto),
        .SEL(SEL), .D(D),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
        .valid(valid), .ptr(ptr), .full(full), .done(done)
    );

    assign q_obs[0] = Q0;
    assign q_obs[1] = Q1;
    assign q_obs[2] = Q2;
    assign q_obs[3] = Q3;
    assign q_obs[4] = Q4;
    assign q_obs[5] = Q5;
    assign q_obs[6] = Q6;
    assign q_obs[7] = Q7;

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; load = 1'b0; auto = 1'b0; SEL = 3'd0; D = 4'h0;
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_obs[i] !== 4'h0) begin
                errors++;
                $display("FAIL reset_q%0d: got %h expected 0", i, q_obs[i]);
            end
        end
        checks++;
        if (valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h expected 00", valid); end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_sel_load();
        auto = 1'b0; SEL = 3'd5; D = 4'hA; load = 1'b1;
        step();
        load = 1'b0; SEL = 3'd1; D = 4'h3;
        for (int i = 0; i < 8; i++) exp_q[i] = 4'h0;
        exp_q[5] = 4'hA;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sel_load_q%0d: got %h expected %h", i, q_obs[i], exp_q[i]);
            end
        end
        checks++;
        if (valid !== 8'b0010_0000) begin errors++; $display("FAIL sel_load_valid: got %b expected 00100000", valid); end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL sel_load_ptr: got %0d expected 0", ptr); end
        checks++;
        if (full !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL sel_load_flags: got full=%b done=%b expected 0 0", full, done);
        end
        // Idle cycle with load low must hold everything
        step();
        checks++;
        if (Q5 !== 4'hA || Q1 !== 4'h0 || valid !== 8'h20) begin
            errors++; $display("FAIL idle_hold: got Q5=%h Q1=%h valid=%h expected a 0 20", Q5, Q1, valid);
        end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        step();
        clear = 1'b0;
        auto = 1'b1; load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            D = 4'(i + 1);
            SEL = 3'd6;
            step();
            checks++;
            if (ptr !== 3'((i + 1) % 8)) begin
                errors++; $display("FAIL auto_ptr_%0d: got %0d expected %0d", i, ptr, (i + 1) % 8);
            end
            checks++;
            if (full !== (i == 7) || done !== (i == 7)) begin
                errors++;
                $display("FAIL auto_flags_%0d: got full=%b done=%b expected %b %b", i, full, done, i == 7, i == 7);
            end
        end
        load = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_obs[i] !== 4'(i + 1)) begin
                errors++; $display("FAIL auto_q%0d: got %h expected %h", i, q_obs[i], 4'(i + 1));
            end
        end
        checks++;
        if (done !== 1'b0 || full !== 1'b1 || valid !== 8'hFF) begin
            errors++; $display("FAIL auto_after: got done=%b full=%b valid=%h expected 0 1 ff", done, full, valid);
        end
    endtask

    task automatic test_full_overwrite();
        auto = 1'b0; SEL = 3'd2; D = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (Q2 !== 4'hF) begin errors++; $display("FAIL full_ow_q2: got %h expected f", Q2); end
        checks++;
        if (full !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL full_ow_flags: got full=%b done=%b expected 1 0", full, done);
        end
        checks++;
        if (ptr !== 3'd0 || Q1 !== 4'h2 || Q3 !== 4'h4) begin
            errors++; $display("FAIL full_ow_others: got ptr=%0d Q1=%h Q3=%h expected 0 2 4", ptr, Q1, Q3);
        end
    endtask

    task automatic test_overwrite_valid();
        clear = 1'b1;
        step();
        clear = 1'b0;
        auto = 1'b0; load = 1'b1;
        SEL = 3'd3; D = 4'h1; step();
        SEL = 3'd3; D = 4'h2; step();
        checks++;
        if (valid !== 8'b0000_1000 || Q3 !== 4'h2) begin
            errors++; $display("FAIL ow_twice: got valid=%b Q3=%h expected 00001000 2", valid, Q3);
        end
        SEL = 3'd4; D = 4'h3; step();
        load = 1'b0;
        checks++;
        if (valid !== 8'b0001_1000 || full !== 1'b0) begin
            errors++; $display("FAIL ow_valid: got valid=%b full=%b expected 00011000 0", valid, full);
        end
        checks++;
        if (Q4 !== 4'h3 || ptr !== 3'd0) begin
            errors++; $display("FAIL ow_q4_ptr: got Q4=%h ptr=%0d expected 3 0", Q4, ptr);
        end
    endtask

    task automatic test_clear_with_load();
        clear = 1'b1; load = 1'b1; auto = 1'b0; SEL = 3'd1; D = 4'h7;
        step();
        clear = 1'b0; load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_obs[i] !== 4'h0) begin
                errors++; $display("FAIL clear_q%0d: got %h expected 0", i, q_obs[i]);
            end
        end
        checks++;
        if (valid !== 8'h00 || ptr !== 3'd0 || full !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: got valid=%h ptr=%0d full=%b done=%b expected 00 0 0 0", valid, ptr, full, done);
        end
    endtask

    task automatic test_reset_after_auto();
        auto = 1'b1; load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            D = 4'(4'hC + i);
            step();
        end
        checks++;
        if (ptr !== 3'd3 || valid !== 8'h07 || Q2 !== 4'hE) begin
            errors++; $display("FAIL auto3: got ptr=%0d valid=%h Q2=%h expected 3 07 e", ptr, valid, Q2);
        end
        auto = 1'b0; SEL = 3'd6; D = 4'h5;
        step();
        checks++;
        if (ptr !== 3'd3 || valid !== 8'h47 || Q6 !== 4'h5) begin
            errors++; $display("FAIL ptr_hold: got ptr=%0d valid=%h Q6=%h expected 3 47 5", ptr, valid, Q6);
        end
        auto = 1'b1; D = 4'h9;
        step();
        load = 1'b0;
        checks++;
        if (ptr !== 3'd4 || valid !== 8'h4F || Q3 !== 4'h9) begin
            errors++; $display("FAIL ptr_resume: got ptr=%0d valid=%h Q3=%h expected 4 4f 9", ptr, valid, Q3);
        end
        reset = 1'b1; load = 1'b1; D = 4'hB;
        step();
        reset = 1'b0; load = 1'b0;
        checks++;
        if (ptr !== 3'd0 || valid !== 8'h00 || full !== 1'b0) begin
            errors++; $display("FAIL reset_after_auto: got ptr=%0d valid=%h full=%b expected 0 00 0", ptr, valid, full);
        end
        checks++;
        if (Q0 !== 4'h0 || Q3 !== 4'h0 || Q6 !== 4'h0) begin
            errors++; $display("FAIL reset_after_auto_q: got Q0=%h Q3=%h Q6=%h expected 0 0 0", Q0, Q3, Q6);
        end
    endtask

    initial begin
        test_reset();
        test_sel_load();
        test_back_to_back();
        test_full_overwrite();
        test_overwrite_valid();
        test_clear_with_load();
        test_reset_after_auto();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
